// File: rtl/sequence_player.sv
// sequence_player: plays round pattern entries as timed LED/tone steps with a blank gap after each.
// Optional halved step timing for long rounds when SEQ_PLAYER_SPEEDUP_EN is defined.
module sequence_player #(
    parameter int ADDR_W     = 5,
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000,
    parameter int SPEED_LEN  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_data,
    output logic [3:0]        led,
    output logic [1:0]        tone_sel,
    output logic              tone_en,
    output logic              busy,
    output logic              done
);
    localparam int MAX_CYC  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int TW       = $clog2(MAX_CYC + 1);
    localparam int ON_FAST  = (ON_CYCLES / 2 > 1) ? ON_CYCLES / 2 : 1;
    localparam int OFF_FAST = (OFF_CYCLES / 2 > 1) ? OFF_CYCLES / 2 : 1;
`ifdef SEQ_PLAYER_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_ON, S_GAP, S_DONE} state_t;

    state_t          state, state_next;
    logic [ADDR_W:0] index, index_next, len;
    logic [TW-1:0]   timer, timer_next, on_time, gap_time;
    logic [1:0]      code;
    logic            fast;

    assign fast     = SPEEDUP && (int'(len) >= SPEED_LEN);
    assign on_time  = fast ? TW'(ON_FAST) : TW'(ON_CYCLES);
    assign gap_time = fast ? TW'(OFF_FAST) : TW'(OFF_CYCLES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            index    <= '0;
            len      <= '0;
            timer    <= '0;
            code     <= '0;
            mem_addr <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
            timer <= timer_next;
            if (state == S_IDLE && start)
                len <= length;
            if (state == S_LOAD)
                code <= mem_data;
            // address is registered on entry to FETCH so read data lands in LOAD
            if (state_next == S_FETCH)
                mem_addr <= index_next[ADDR_W-1:0];
        end
    end

    always_comb begin
        state_next = state;
        index_next = index;
        timer_next = timer;
        unique case (state)
            S_IDLE: if (start) begin
                state_next = (length == '0) ? S_DONE : S_FETCH;
                index_next = '0;
            end
            S_FETCH: state_next = S_LOAD;
            S_LOAD: begin
                state_next = S_ON;
                timer_next = on_time;
            end
            S_ON: if (timer == TW'(1)) begin
                state_next = S_GAP;
                timer_next = gap_time;
            end else
                timer_next = timer - TW'(1);
            S_GAP: if (timer == TW'(1)) begin
                state_next = (index == len - (ADDR_W+1)'(1)) ? S_DONE : S_FETCH;
                index_next = (index == len - (ADDR_W+1)'(1)) ? index : index + (ADDR_W+1)'(1);
            end else
                timer_next = timer - TW'(1);
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort)
            state_next = S_IDLE;
    end

    assign led      = (state == S_ON) ? (4'b0001 << code) : 4'b0000;
    assign tone_sel = (state == S_ON) ? code : 2'b00;
    assign tone_en  = (state == S_ON);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed bench for sequence_player with ON=4, OFF=2, SPEED_LEN=4.
module tb_sequence_player;
    localparam int ADDR_W = 5;
`ifdef SEQ_PLAYER_SPEEDUP_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W:0]   length = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_data;
    logic [3:0]        led;
    logic [1:0]        tone_sel;
    logic              tone_en, busy, done;
    logic [1:0]        mem [32];
    int                checks = 0;
    int                errors = 0;

    sequence_player #(.ADDR_W(ADDR_W), .ON_CYCLES(4), .OFF_CYCLES(2), .SPEED_LEN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .length(length),
        .mem_addr(mem_addr), .mem_data(mem_data), .led(led), .tone_sel(tone_sel),
        .tone_en(tone_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) mem_data <= mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic play(input int n, input bit repulse);
        int on_t, gap_t, per, total, p, s;
        logic [3:0] exp_led;
        logic [1:0] exp_sel;
        logic [ADDR_W-1:0] addr0;
        on_t  = (FAST && n >= 4) ? 2 : 4;
        gap_t = (FAST && n >= 4) ? 1 : 2;
        per   = 2 + on_t + gap_t;
        total = n * per + 1;
        @(negedge clk);
        addr0  = mem_addr;
        length = (ADDR_W+1)'(n);
        start  = 1'b1;
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            start = (repulse && k == 5) ? 1'b1 : 1'b0;
            if (repulse && k == 5) length = 1;
            p = (k - 1) % per;
            s = (k - 1) / per;
            exp_led = (k < total && p >= 2 && p < 2 + on_t) ? (4'b0001 << mem[s]) : 4'b0000;
            exp_sel = (exp_led != 0) ? mem[s] : 2'b00;
            check($sformatf("led n%0d k%0d", n, k), 32'(led), 32'(exp_led));
            check($sformatf("tone_sel n%0d k%0d", n, k), 32'(tone_sel), 32'(exp_sel));
            check($sformatf("tone_en n%0d k%0d", n, k), 32'(tone_en), 32'(exp_led != 0));
            check($sformatf("done n%0d k%0d", n, k), 32'(done), 32'(k == total));
            check($sformatf("busy n%0d k%0d", n, k), 32'(busy), 32'd1);
            if (k < total && p == 0)
                check($sformatf("mem_addr n%0d k%0d", n, k), 32'(mem_addr), 32'(s));
            if (n == 0)
                check("mem_addr held len0", 32'(mem_addr), 32'(addr0));
        end
        @(negedge clk);
        check($sformatf("busy_after n%0d", n), 32'(busy), 32'd0);
        check($sformatf("done_after n%0d", n), 32'(done), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 2'((i * 3 + 1) % 4);
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3; mem[3] = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'($urandom_range(0, 1));
            length = 3;
            check("rst led", 32'(led), 0);
            check("rst tone", 32'({tone_en, tone_sel}), 0);
            check("rst busy_done", 32'({busy, done}), 0);
            check("rst mem_addr", 32'(mem_addr), 0);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check("idle busy", 32'(busy), 0);
        check("idle led", 32'(led), 0);

        play(3, 1'b0);
        check("addr after play", 32'(mem_addr), 2);
        play(0, 1'b0);
        check("addr after len0", 32'(mem_addr), 2);
        play(3, 1'b1);

        @(negedge clk);
        length = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("abort pre led", 32'(led), 32'b0001);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort led", 32'(led), 0);
        check("abort busy", 32'(busy), 0);
        check("abort done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort no done", 32'({busy, done}), 0);
        end
        play(3, 1'b0);

        play(4, 1'b0);
        play(32, 1'b0);

        @(negedge clk);
        length = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre reset led", 32'(led), 32'b0100);
        #2 rst = 1'b0;
        #1;
        check("midrst led", 32'(led), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst addr", 32'(mem_addr), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst no done", 32'({busy, done}), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end
endmodule
